// File: rtl/stopwatch_ctrl.sv
// m:ss.t stopwatch controller: run/pause/lap FSM, tick prescaler and BCD digit cascade.
// Define STOPWATCH_SAT_EN to saturate at 9:59.9 and pause instead of wrapping.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 10,
    parameter int TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_ss,
    input  logic        btn_lr,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        running,
    output logic        overflow
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] T_MAX = 4'(TENS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t cur, nxt;

    logic [PW-1:0] pre;
    logic [3:0]    tn, so, st, mn;
    logic [15:0]   lap;
    logic [15:0]   live;
    logic          ovf;
    logic          run_q, tick, at_max, sat_hit;
    logic          c0, c1, c2;
    logic          clear, cap;

    assign live   = {mn, st, so, tn};
    assign run_q  = (cur == RUN) || (cur == LAP);
    assign tick   = run_q && (pre == PRE_LAST);
    assign at_max = (mn == 4'd9) && (st == T_MAX) && (so == 4'd9) && (tn == 4'd9);
    assign c0     = (tn == 4'd9);
    assign c1     = c0 && (so == 4'd9);
    assign c2     = c1 && (st == T_MAX);

`ifdef STOPWATCH_SAT_EN
    assign sat_hit = tick && at_max;
`else
    assign sat_hit = 1'b0;
`endif

    assign clear = (cur == PAUSE) && (nxt == IDLE);
    assign cap   = (cur == RUN) && (nxt == LAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // btn_ss has priority; a saturating tick forces a pause
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: begin
                if (btn_ss) nxt = RUN;
            end
            RUN: begin
                if (btn_ss || sat_hit) nxt = PAUSE;
                else if (btn_lr)       nxt = LAP;
            end
            LAP: begin
                if (btn_ss || sat_hit) nxt = PAUSE;
                else if (btn_lr)       nxt = RUN;
            end
            PAUSE: begin
                if (btn_ss)      nxt = RUN;
                else if (btn_lr) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        disp     = (cur == LAP) ? lap : live;
        running  = run_q;
        state    = cur;
        overflow = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            tn  <= 4'd0;
            so  <= 4'd0;
            st  <= 4'd0;
            mn  <= 4'd0;
            lap <= 16'h0000;
            ovf <= 1'b0;
        end else if (clear) begin
            pre <= '0;
            tn  <= 4'd0;
            so  <= 4'd0;
            st  <= 4'd0;
            mn  <= 4'd0;
            lap <= 16'h0000;
            ovf <= 1'b0;
        end else begin
            if (cur == IDLE) begin
                pre <= '0;
            end else if (run_q) begin
                pre <= tick ? '0 : pre + PW'(1);
            end
            if (tick && !sat_hit) begin
                tn <= c0 ? 4'd0 : tn + 4'd1;
                if (c0) so <= (so == 4'd9) ? 4'd0 : so + 4'd1;
                if (c1) st <= (st == T_MAX) ? 4'd0 : st + 4'd1;
                if (c2) mn <= (mn == 4'd9) ? 4'd0 : mn + 4'd1;
            end
            if (tick && at_max) begin
                ovf <= 1'b1;
            end
            // capture uses the pre-edge digits, even if a tick lands here
            if (cap) begin
                lap <= live;
            end
        end
    end

endmodule
